// File: rtl/pc_sequencer_if.sv
// Instruction-memory request/response bus between the PC sequencer
// (master) and the instruction memory (slave).
interface pc_sequencer_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;

    modport master (
        output if_req,
        output if_addr,
        input  if_ready,
        input  if_rdata
    );

    modport slave (
        input  if_req,
        input  if_addr,
        output if_ready,
        output if_rdata
    );
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer: drives the instruction-fetch request stream, delivers one
// fetched instruction per cycle to IF/ID, and applies branch redirects
// (with delay slot) and exception redirects (highest priority).
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 id_valid,
    input  logic                 branch_flag,
    input  logic [31:0]          branch_addr,
    input  logic                 exc_flag,
    input  logic [31:0]          exc_addr,
    pc_sequencer_if.master       mem,
    output logic                 fetch_valid,
    output logic [31:0]          fetch_pc,
    output logic [31:0]          fetch_inst
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic        if_req_q, if_req_d;
    logic [31:0] if_addr_q, if_addr_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] fetch_inst_q, fetch_inst_d;

    logic        branch_acc;
    logic [31:0] seq_pc;
    logic [31:0] next_pc;
    logic        deliver;

    // A branch counts only when ID really holds it, the pipe moves and no
    // exception pre-empts it.
    assign branch_acc = branch_flag & id_valid & ~stall & ~exc_flag;
    assign seq_pc     = pc_q + 32'd4;
    // A parked redirect wins over a fresh one: it belongs to an older branch
    // whose delay slot is the fetch now completing.
    assign next_pc    = pend_valid_q ? pend_addr_q :
                        branch_acc   ? branch_addr : seq_pc;

    // Next-state, redirect bookkeeping and registered output computation.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_addr_d    = req_addr_q;
        pend_valid_d  = pend_valid_q;
        pend_addr_d   = pend_addr_q;
        hold_inst_d   = hold_inst_q;
        fetch_pc_d    = fetch_pc_q;
        fetch_inst_d  = fetch_inst_q;
        deliver       = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (mem.if_ready && !exc_flag) begin
                    if (stall) begin
                        // Memory will not wait for us: park the word and its pc.
                        hold_inst_d = mem.if_rdata;
                        req_addr_d  = pc_q;
                        state_d     = HOLD;
                    end else begin
                        deliver      = 1'b1;
                        fetch_pc_d   = pc_q;
                        fetch_inst_d = mem.if_rdata;
                    end
                end else if (!mem.if_ready && exc_flag) begin
                    // The outstanding request must finish at its original
                    // address; remember it while pc moves to the handler.
                    req_addr_d = pc_q;
                    state_d    = DRAIN;
                end
            end
            HOLD: begin
                if (exc_flag) begin
                    state_d = FETCH;
                end else if (!stall) begin
                    deliver      = 1'b1;
                    fetch_pc_d   = req_addr_q;
                    fetch_inst_d = hold_inst_q;
                    state_d      = FETCH;
                end
            end
            DRAIN: begin
                if (mem.if_ready) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Delivery and exception are mutually exclusive (delivery needs
        // !exc_flag), so this ordering only separates branch parking.
        if (deliver) begin
            pc_d         = next_pc;
            pend_valid_d = 1'b0;
        end else if (exc_flag) begin
            pc_d         = exc_addr;
            pend_valid_d = 1'b0;
        end else if (branch_acc) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = branch_addr;
        end

        fetch_valid_d = deliver;
        if_req_d      = (state_d == FETCH) || (state_d == DRAIN);
        if_addr_d     = (state_d == DRAIN) ? req_addr_d : pc_d;
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            req_addr_q    <= 32'd0;
            pend_valid_q  <= 1'b0;
            pend_addr_q   <= 32'd0;
            hold_inst_q   <= 32'd0;
            if_req_q      <= 1'b0;
            if_addr_q     <= 32'd0;
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= 32'd0;
            fetch_inst_q  <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            pend_valid_q  <= pend_valid_d;
            pend_addr_q   <= pend_addr_d;
            hold_inst_q   <= hold_inst_d;
            if_req_q      <= if_req_d;
            if_addr_q     <= if_addr_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_inst_q  <= fetch_inst_d;
        end
    end

    assign mem.if_req  = if_req_q;
    assign mem.if_addr = if_addr_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_pc    = fetch_pc_q;
    assign fetch_inst  = fetch_inst_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer against a transaction-level reference
// model, with directed windows for reset-release sequencing, address wrap
// and an asynchronous reset while draining.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        id_valid;
    logic        branch_flag;
    logic [31:0] branch_addr;
    logic        exc_flag;
    logic [31:0] exc_addr;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_inst;

    int n_cmp = 0;
    int n_bad = 0;

    pc_sequencer_if mem ();

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .id_valid    (id_valid),
        .branch_flag (branch_flag),
        .branch_addr (branch_addr),
        .exc_flag    (exc_flag),
        .exc_addr    (exc_addr),
        .mem         (mem.master),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .fetch_inst  (fetch_inst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the sequencer seen as "a request is out at some
    // address", "a finished word is parked", "an abandoned request is being
    // drained", plus the program counter and at most one parked redirect.
    bit          m_boot, m_req, m_buf_v, m_drain, m_pend_v, m_fv;
    logic [31:0] m_pc, m_addr, m_drain_a, m_pend_a, m_buf_pc, m_buf_inst, m_fpc, m_finst;

    task automatic model_reset();
        m_boot = 1; m_req = 0; m_buf_v = 0; m_drain = 0; m_pend_v = 0; m_fv = 0;
        m_pc = RST_PC; m_addr = 0; m_drain_a = 0; m_pend_a = 0;
        m_buf_pc = 0; m_buf_inst = 0; m_fpc = 0; m_finst = 0;
    endtask

    task automatic model_step(input bit st, input bit idv, input bit br, input bit ex,
                              input bit rdy, input logic [31:0] ba, input logic [31:0] ea,
                              input logic [31:0] rd);
        bit          acc;
        bit          dlv;
        logic [31:0] tgt;
        acc = br && idv && !st && !ex;
        tgt = m_pend_v ? m_pend_a : (acc ? ba : m_pc + 32'd4);
        dlv = 0;
        if (!m_boot) begin
            if (m_buf_v) begin
                if (ex) m_buf_v = 0;
                else if (!st) begin
                    dlv = 1; m_fpc = m_buf_pc; m_finst = m_buf_inst; m_buf_v = 0;
                end
            end else if (m_drain) begin
                if (rdy) m_drain = 0;
            end else if (rdy && !ex) begin
                if (st) begin
                    m_buf_v = 1; m_buf_pc = m_pc; m_buf_inst = rd;
                end else begin
                    dlv = 1; m_fpc = m_pc; m_finst = rd;
                end
            end else if (!rdy && ex) begin
                m_drain = 1; m_drain_a = m_pc;
            end
        end
        m_boot = 0;
        m_fv = dlv;
        if (dlv) begin
            m_pc = tgt; m_pend_v = 0;
        end else if (ex) begin
            m_pc = ea; m_pend_v = 0;
        end else if (acc) begin
            m_pend_v = 1; m_pend_a = ba;
        end
        m_req  = !m_buf_v;
        m_addr = m_drain ? m_drain_a : m_pc;
    endtask

    task automatic check_outputs();
        chk("if_req", {31'd0, mem.if_req}, {31'd0, m_req});
        if (m_req) chk("if_addr", mem.if_addr, m_addr);
        chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_fv});
        if (m_fv) begin
            chk("fetch_pc", fetch_pc, m_fpc);
            chk("fetch_inst", fetch_inst, m_finst);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_if_req"}, {31'd0, mem.if_req}, 32'd0);
        chk({tag, "_fetch_valid"}, {31'd0, fetch_valid}, 32'd0);
        chk({tag, "_fetch_pc"}, fetch_pc, 32'd0);
        chk({tag, "_fetch_inst"}, fetch_inst, 32'd0);
    endtask

    initial begin
        bit          st, idv, br, ex, rdy, did_rst;
        logic [31:0] ba, ea, rd;
        did_rst = 0;
        rst_n = 1'b0; stall = 0; id_valid = 0; branch_flag = 0; exc_flag = 0;
        branch_addr = 0; exc_addr = 0;
        mem.if_ready = 1'b0; mem.if_rdata = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            check_outputs();
            if (cyc == 1) chk("boot_addr0", mem.if_addr, RST_PC);
            if (cyc == 2) begin
                chk("boot_addr1", mem.if_addr, RST_PC + 32'd4);
                chk("boot_fpc0", fetch_pc, RST_PC);
            end
            if (cyc == 3) begin
                chk("boot_addr2", mem.if_addr, RST_PC + 32'd8);
                chk("boot_fpc1", fetch_pc, RST_PC + 32'd4);
            end
            if (cyc == 201) chk("wrap_addr_f8", mem.if_addr, 32'hFFFFFFF8);
            if (cyc == 202) chk("wrap_addr_fc", mem.if_addr, 32'hFFFFFFFC);
            if (cyc == 203) chk("wrap_addr_00", mem.if_addr, 32'h00000000);

            if (!did_rst && cyc > 1500 && (m_drain || cyc == 2900)) begin
                did_rst = 1;
                rst_n = 1'b0;
                #1;
                check_reset_outputs("async_rst");
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
                check_outputs();
                stall = 0; id_valid = 0; branch_flag = 0; exc_flag = 0; mem.if_ready = 0;
                model_step(0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0);
                @(negedge clk);
                chk("rst_first_req", {31'd0, mem.if_req}, 32'd1);
                chk("rst_first_addr", mem.if_addr, RST_PC);
                continue;
            end

            rd = $urandom;
            ba = $urandom & 32'hFFFFFFFC;
            ea = ($urandom_range(0, 1) == 0) ? 32'hBFC00380 : ($urandom & 32'hFFFFFFFC);
            if (cyc < 4 || (cyc >= 201 && cyc < 206)) begin
                st = 0; idv = 0; br = 0; ex = 0; rdy = m_req;
            end else if (cyc == 200) begin
                st = 0; idv = 0; br = 0; ex = 1; ea = 32'hFFFFFFF8; rdy = m_req;
            end else begin
                st  = ($urandom_range(0, 3) == 0);
                idv = ($urandom_range(0, 9) < 7);
                br  = ($urandom_range(0, 4) == 0);
                ex  = ($urandom_range(0, 24) == 0);
                rdy = m_req && ($urandom_range(0, 1) == 0);
            end

            stall = st; id_valid = idv; branch_flag = br; branch_addr = ba;
            exc_flag = ex; exc_addr = ea;
            mem.if_ready = rdy; mem.if_rdata = rd;
            model_step(st, idv, br, ex, rdy, ba, ea, rd);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
